// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int EV_W = 10;
  localparam int EXT  = 9;
  localparam int BRK  = 8;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // PS/2 uses odd parity across the data byte and the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for decoded key events; registered head, level and valid.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int EV_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [EV_W-1:0]          push_data,
  input  logic                     pop,
  output logic [EV_W-1:0]          rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [LW-1:0]   level_r, level_next_s, remain_s;
  logic [EV_W-1:0] rd_data_r, head_next_s;
  logic            valid_r, do_push_s, do_pop_s, full_s;

  // Accept/pop decisions and the head value that follows them.
  always_comb begin
    full_s       = (level_r == LW'(DEPTH));
    do_pop_s     = pop && valid_r;
    do_push_s    = push && (!full_s || do_pop_s);
    rd_next_s    = rd_ptr_r + AW'(do_pop_s);
    remain_s     = level_r - LW'(do_pop_s);
    level_next_s = remain_s + LW'(do_push_s);
    if (remain_s == LW'(0)) begin
      head_next_s = do_push_s ? push_data : {EV_W{1'b0}};
    end else begin
      head_next_s = mem[rd_next_s];
    end
  end

  // Storage array; no reset needed since reads are gated by level.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      level_r   <= LW'(0);
      valid_r   <= 1'b0;
      rd_data_r <= {EV_W{1'b0}};
    end else begin
      wr_ptr_r  <= wr_ptr_r + AW'(do_push_s);
      rd_ptr_r  <= rd_next_s;
      level_r   <= level_next_s;
      valid_r   <= (level_next_s != LW'(0));
      rd_data_r <= head_next_s;
    end
  end

  assign rd_data = rd_data_r;
  assign full    = full_s;
  assign empty   = !valid_r;
  assign level   = level_r;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchroniser, clock filter, frame FSM, timeout, event FIFO.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefix bytes into ext/brk flags.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DEPTH          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2c,
  input  logic                   ps2d,
  output logic [EV_W-1:0]        rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          c_meta_r, c_sync_r, d_meta_r, d_sync_r, c_filt_r, c_filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s, timeout_s;
  logic [TW-1:0] to_cnt_r;

  ps2_state_e    state_r, state_next_s;
  logic [2:0]    bitcnt_r, bitcnt_next_s;
  logic [7:0]    shift_r, shift_next_s;
  logic          par_r, par_next_s;
  logic          good_s, perr_s, ferr_s;

  logic            push_s, push_r, pop_s, fifo_full_s, fifo_empty_s;
  logic [EV_W-1:0] push_data_s, push_data_r;
  logic            busy_r, parity_err_r, frame_err_r, overflow_r;

  // Two-flop synchronisers plus a run-length filter on the clock line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_meta_r   <= 1'b1;
      c_sync_r   <= 1'b1;
      d_meta_r   <= 1'b1;
      d_sync_r   <= 1'b1;
      c_filt_r   <= 1'b1;
      c_filt_d_r <= 1'b1;
      filt_cnt_r <= FW'(0);
    end else begin
      c_meta_r   <= ps2c;
      c_sync_r   <= c_meta_r;
      d_meta_r   <= ps2d;
      d_sync_r   <= d_meta_r;
      c_filt_d_r <= c_filt_r;
      if (c_sync_r == c_filt_r) begin
        filt_cnt_r <= FW'(0);
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        c_filt_r   <= c_sync_r;
        filt_cnt_r <= FW'(0);
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s    = c_filt_d_r && !c_filt_r;
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Inter-edge timeout counter, idle while no frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= TW'(0);
    end else if (fall_s || timeout_s || state_r == ST_IDLE) begin
      to_cnt_r <= TW'(0);
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Frame FSM next state; only a fall event or a timeout moves it.
  always_comb begin
    state_next_s  = state_r;
    bitcnt_next_s = bitcnt_r;
    shift_next_s  = shift_r;
    par_next_s    = par_r;
    good_s        = 1'b0;
    perr_s        = 1'b0;
    ferr_s        = 1'b0;
    if (timeout_s) begin
      state_next_s = ST_IDLE;
      ferr_s       = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!d_sync_r) begin
            state_next_s  = ST_DATA;
            bitcnt_next_s = 3'd0;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_next_s[bitcnt_r] = d_sync_r;
          if (bitcnt_r == 3'd7) begin
            state_next_s = ST_PARITY;
          end else begin
            bitcnt_next_s = bitcnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          par_next_s   = d_sync_r;
          state_next_s = ST_STOP;
        end
        ST_STOP: begin
          state_next_s = ST_IDLE;
          if (!d_sync_r) begin
            ferr_s = 1'b1;
          end else if (!odd_parity_ok(shift_r, par_r)) begin
            perr_s = 1'b1;
          end else begin
            good_s = 1'b1;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      bitcnt_r <= 3'd0;
      shift_r  <= 8'h00;
      par_r    <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      bitcnt_r <= bitcnt_next_s;
      shift_r  <= shift_next_s;
      par_r    <= par_next_s;
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_pend_r, brk_pend_r, ext_pend_next_s, brk_pend_next_s;

  // Prefix bytes only set flags; the next real code carries them.
  always_comb begin
    ext_pend_next_s   = ext_pend_r;
    brk_pend_next_s   = brk_pend_r;
    push_s            = 1'b0;
    push_data_s       = {EV_W{1'b0}};
    push_data_s[7:0]  = shift_r;
    push_data_s[EXT]  = ext_pend_r;
    push_data_s[BRK]  = brk_pend_r;
    if (good_s) begin
      if (shift_r == PS2_EXT) begin
        ext_pend_next_s = 1'b1;
      end else if (shift_r == PS2_BRK) begin
        brk_pend_next_s = 1'b1;
      end else begin
        push_s          = 1'b1;
        ext_pend_next_s = 1'b0;
        brk_pend_next_s = 1'b0;
      end
    end else if (perr_s || ferr_s) begin
      ext_pend_next_s = 1'b0;
      brk_pend_next_s = 1'b0;
    end else begin
      push_s = 1'b0;
    end
  end

  // Pending prefix flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
    end else begin
      ext_pend_r <= ext_pend_next_s;
      brk_pend_r <= brk_pend_next_s;
    end
  end
`else
  assign push_s      = good_s;
  assign push_data_s = {2'b00, shift_r};
`endif

  assign pop_s = rx_ready && !fifo_empty_s;

  // Registered push request and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_r       <= 1'b0;
      push_data_r  <= {EV_W{1'b0}};
      busy_r       <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      push_r       <= push_s;
      push_data_r  <= push_data_s;
      busy_r       <= (state_next_s != ST_IDLE);
      parity_err_r <= perr_s;
      frame_err_r  <= ferr_s;
      overflow_r   <= push_r && fifo_full_s && !pop_s;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .EV_W  (EV_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (push_data_r),
    .pop       (pop_s),
    .rd_data   (rx_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  assign rx_valid   = !fifo_empty_s;
  assign busy       = busy_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overflow   = overflow_r;

endmodule
